multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: a registered-state FSM whose datapath strobes
// are decoded combinationally from the state, the latched opcode and mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IMMWB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    assign state = state_q;

    // NOTE: every output gets a default before the case so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_ADD;
        ExtSel      = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Reset holds FETCH decode but must not load IR or PC.
                IRWrite = mem_ready && !rst;
                PCWrite = mem_ready && !rst;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB  = 2'b11;
                ExtSel   = 1'b1;
                opcode_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_R:                      state_d = S_EXEC;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtSel  = 1'b1;
                state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtSel  = (opcode_q == OP_ADDI);
                if (opcode_q == OP_ANDI)     ALUOp = ALU_AND;
                else if (opcode_q == OP_ORI) ALUOp = ALU_OR;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                ExtSel   = (opcode_q == OP_ADDI);
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, async
// reset corner cases and randomized instruction streams against a path model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA, ExtSel, illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: PW PWC IorD MR MW IRW M2R RW RD ASA | ASB | PCS | ALUOp | Ext | ill
    logic [18:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                   ALUOp, ExtSel, illegal};

    localparam logic [18:0] O_F_RDY  = {10'b1001010000, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_F_WAIT = {10'b0001000000, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_DEC    = {10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b1, 1'b0};
    localparam logic [18:0] O_DECILL = {10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b1, 1'b1};
    localparam logic [18:0] O_MADR   = {10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b1, 1'b0};
    localparam logic [18:0] O_MRD    = {10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_MWB    = {10'b0000001100, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_MWR    = {10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_EXEC   = {10'b0000000001, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
    localparam logic [18:0] O_ALUWB  = {10'b0000000110, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_BR     = {10'b0100000001, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0};
    localparam logic [18:0] O_JUMP   = {10'b1000000000, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] O_IX_ADD = {10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b1, 1'b0};
    localparam logic [18:0] O_IX_AND = {10'b0000000001, 2'b10, 2'b00, 3'b011, 1'b0, 1'b0};
    localparam logic [18:0] O_IX_OR  = {10'b0000000001, 2'b10, 2'b00, 3'b100, 1'b0, 1'b0};
    localparam logic [18:0] O_IWB_S  = {10'b0000000100, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
    localparam logic [18:0] O_IWB_Z  = {10'b0000000100, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, BAD = 6'b111111;

    typedef struct {
        logic        mr;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [18:0] o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs away from the rising edge and sample once they settle.
    task automatic drive(input logic mr, input logic [5:0] op);
        @(negedge clk);
        mem_ready = mr;
        opcode    = op;
        #1;
    endtask

    // Higher-level model: the ordered list of states an instruction visits.
    function automatic void path_of(input logic [5:0] op, output int p[$]);
        case (op)
            LW:               p = '{0, 1, 2, 3, 4};
            SW:               p = '{0, 1, 2, 5};
            RT:               p = '{0, 1, 6, 7};
            BEQ:              p = '{0, 1, 8};
            JMP:              p = '{0, 1, 9};
            ADDI, ANDI, ORI:  p = '{0, 1, 10, 11};
            default:          p = '{0, 1};
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = LW;

        vecs = '{
            '{1'b1, LW,   4'd0,  O_F_RDY}, '{1'b1, LW,  4'd1, O_DEC},
            '{1'b1, BAD,  4'd2,  O_MADR},  '{1'b0, BAD, 4'd3, O_MRD},
            '{1'b1, BAD,  4'd3,  O_MRD},   '{1'b1, BAD, 4'd4, O_MWB},
            '{1'b1, ORI,  4'd0,  O_F_RDY}, '{1'b1, ORI, 4'd1, O_DEC},
            '{1'b1, RT,   4'd10, O_IX_OR}, '{1'b1, RT,  4'd11, O_IWB_Z},
            '{1'b0, SW,   4'd0,  O_F_WAIT},'{1'b1, SW,  4'd0, O_F_RDY},
            '{1'b1, SW,   4'd1,  O_DEC},   '{1'b1, LW,  4'd2, O_MADR},
            '{1'b0, LW,   4'd5,  O_MWR},   '{1'b0, LW,  4'd5, O_MWR},
            '{1'b0, LW,   4'd5,  O_MWR},   '{1'b1, LW,  4'd5, O_MWR},
            '{1'b1, BEQ,  4'd0,  O_F_RDY}, '{1'b1, BEQ, 4'd1, O_DEC},
            '{1'b1, BAD,  4'd8,  O_BR},
            '{1'b1, JMP,  4'd0,  O_F_RDY}, '{1'b1, JMP, 4'd1, O_DEC},
            '{1'b1, BAD,  4'd9,  O_JUMP},
            '{1'b1, RT,   4'd0,  O_F_RDY}, '{1'b1, RT,  4'd1, O_DEC},
            '{1'b1, BAD,  4'd6,  O_EXEC},  '{1'b1, BAD, 4'd7, O_ALUWB},
            '{1'b1, ADDI, 4'd0,  O_F_RDY}, '{1'b1, ADDI, 4'd1, O_DEC},
            '{1'b1, ORI,  4'd10, O_IX_ADD},'{1'b1, ORI, 4'd11, O_IWB_S},
            '{1'b1, ANDI, 4'd0,  O_F_RDY}, '{1'b1, ANDI, 4'd1, O_DEC},
            '{1'b1, ADDI, 4'd10, O_IX_AND},'{1'b1, ADDI, 4'd11, O_IWB_Z},
            '{1'b1, BAD,  4'd0,  O_F_RDY}, '{1'b1, BAD, 4'd1, O_DECILL},
            '{1'b0, RT,   4'd0,  O_F_WAIT}
        };

        // Reset state: FETCH decode without IR/PC writes.
        #6;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'(outs), 32'(O_F_WAIT));
        mem_ready = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].mr, vecs[i].op);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].o));
        end

        // Async reset mid-store: MemWrite and IorD drop before the next edge.
        drive(1'b1, SW);
        drive(1'b1, SW);
        drive(1'b1, SW);
        drive(1'b0, SW);
        check("pre_rst_memwr", 32'(state), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_memwrite", 32'(MemWrite), 32'd0);
        check("async_rst_iord", 32'(IorD), 32'd0);
        check("async_rst_outs", 32'(outs), 32'(O_F_WAIT));
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("post_rst_wait", 32'(outs), 32'(O_F_WAIT));
        drive(1'b1, JMP);
        check("post_rst_fetch", 32'(outs), 32'(O_F_RDY));
        drive(1'b1, JMP);
        check("post_rst_decode", 32'(state), 32'd1);
        drive(1'b1, RT);
        check("post_rst_jump", 32'(state), 32'd9);

        // Randomized instruction stream against the path model.
        for (int n = 0; n < 300; n++) begin
            int p[$];
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 8));
            case (sel)
                0: op = LW;   1: op = SW;   2: op = RT;   3: op = BEQ;
                4: op = JMP;  5: op = ADDI; 6: op = ANDI; 7: op = ORI;
                default: op = 6'($urandom);
            endcase
            path_of(op, p);
            foreach (p[k]) begin
                int  waits;
                logic mr;
                bit  done;
                waits = 0;
                done  = 0;
                while (!done) begin
                    mr = ($urandom_range(0, 2) != 0) || (waits >= 6);
                    drive(mr, (k < 2) ? op : 6'($urandom));
                    check("rnd_state", 32'(state), 32'(p[k]));
                    check("rnd_strobes",
                          32'({MemRead, MemWrite, RegWrite, IRWrite, illegal}),
                          32'({p[k] == 0 || p[k] == 3, p[k] == 5,
                               p[k] == 4 || p[k] == 7 || p[k] == 11,
                               p[k] == 0 && mr, p[k] == 1 && p.size() == 2}));
                    if ((p[k] == 0 || p[k] == 3 || p[k] == 5) && !mr) waits++;
                    else done = 1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
